color_frame_scheduler: RTL and testbench

- Periodic frame scheduler that sequences the colour-sensor datapath.
- Per frame: on a period tick, reads the five channels (clear, red, green, blue, infrared) from the ADC front-end via a req/valid handshake into shadow registers.
- Commits the shadows atomically to a stable snapshot, then triggers the I2C sender and supervises its done/NACK result, with bounded retries.
- Sits between the ADC front-end and the I2C transmit controller; the snapshot outputs feed the sender's channel data inputs.

---
 rtl/color_sensor_pkg.sv | 22 ++
 rtl/frame_period_timer.sv | 44 ++++
 rtl/color_frame_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_color_frame_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_sensor_pkg.sv
// Shared definitions for the colour-sensor datapath: channel indices and scheduler states.
package color_sensor_pkg;

    localparam int unsigned CH_W   = 3;
    localparam int unsigned NUM_CH = 5;

    localparam logic [CH_W-1:0] CH_CLEAR = 3'd0;
    localparam logic [CH_W-1:0] CH_RED   = 3'd1;
    localparam logic [CH_W-1:0] CH_GREEN = 3'd2;
    localparam logic [CH_W-1:0] CH_BLUE  = 3'd3;
    localparam logic [CH_W-1:0] CH_IR    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_TX_START  = 3'd4,
        ST_TX_WAIT   = 3'd5
    } sched_state_e;

endpackage

// File: rtl/frame_period_timer.sv
// Frame period down-counter: load/run control, single-cycle tick at zero with automatic reload.
module frame_period_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick_c
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] reload_c;

    // A period of 0 behaves like 1: reload value 0 ticks every cycle.
    assign reload_c = (period == '0) ? '0 : period - PERIOD_W'(1);

    // Next count: explicit load wins, otherwise count down and reload on tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (load) begin
            cnt_d = reload_c;
        end else if (run) begin
            if (cnt_q == '0) begin
                tick_c = 1'b1;
                cnt_d  = reload_c;
            end else begin
                cnt_d = cnt_q - PERIOD_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/color_frame_scheduler.sv
// Frame scheduler: periodic ADC capture into shadows, atomic snapshot commit, I2C send with retries.
module color_frame_scheduler
    import color_sensor_pkg::*;
#(
    parameter int unsigned PERIOD_W  = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                err_clr,
    output logic                adc_req,
    output logic [2:0]          adc_ch,
    input  logic                adc_valid,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                tx_start,
    input  logic                tx_busy,
    input  logic                tx_done,
    input  logic                tx_nack,
    output logic [DATA_W-1:0]   clear_data,
    output logic [DATA_W-1:0]   red_data,
    output logic [DATA_W-1:0]   green_data,
    output logic [DATA_W-1:0]   blue_data,
    output logic [DATA_W-1:0]   infrared_data,
    output logic [7:0]          frame_cnt,
    output logic                err_overrun,
    output logic                err_nack
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    sched_state_e        state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [DATA_W-1:0]   shadow_q [NUM_CH];
    logic [DATA_W-1:0]   shadow_d [NUM_CH];
    logic [DATA_W-1:0]   snap_q   [NUM_CH];
    logic [DATA_W-1:0]   snap_d   [NUM_CH];
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                adc_req_q, adc_req_d;
    logic [CH_W-1:0]     adc_ch_q, adc_ch_d;
    logic                tx_start_q, tx_start_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_nack_q, err_nack_d;
    logic                timer_load_c;
    logic                timer_run_c;
    logic                tick_c;

    // Timer only advances while enabled and out of IDLE; it is (re)loaded when leaving IDLE.
    assign timer_run_c = enable && (state_q != ST_IDLE);

    frame_period_timer #(
        .PERIOD_W(PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load_c),
        .run    (timer_run_c),
        .period (period),
        .tick_c (tick_c)
    );

    // Next-state, datapath and registered-output decode for the frame sequence.
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        retry_d       = retry_q;
        shadow_d      = shadow_q;
        snap_d        = snap_q;
        frame_cnt_d   = frame_cnt_q;
        tx_start_d    = 1'b0;
        err_overrun_d = err_overrun_q;
        err_nack_d    = err_nack_q;
        timer_load_c  = 1'b0;

        // Clear first so that a same-cycle set below takes priority.
        if (err_clr) begin
            err_overrun_d = 1'b0;
            err_nack_d    = 1'b0;
        end

        // A tick while a frame is in flight is dropped and flagged.
        if (tick_c && (state_q != ST_WAIT_TICK)) begin
            err_overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    timer_load_c = 1'b1;
                    state_d      = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick_c) begin
                    ch_d    = CH_CLEAR;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (adc_valid && adc_req_q) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (ch_q == CH_W'(i)) begin
                            shadow_d[i] = adc_data;
                        end
                    end
                    if (ch_q == CH_IR) begin
                        ch_d    = CH_CLEAR;
                        state_d = ST_COMMIT;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                snap_d      = shadow_q;
                frame_cnt_d = frame_cnt_q + 8'd1;
                retry_d     = '0;
                state_d     = ST_TX_START;
            end
            ST_TX_START: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (tx_nack) begin
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_TX_START;
                    end else begin
                        err_nack_d = 1'b1;
                        state_d    = enable ? ST_WAIT_TICK : ST_IDLE;
                    end
                end else if (tx_done) begin
                    state_d = enable ? ST_WAIT_TICK : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        adc_req_d = (state_d == ST_CAPTURE);
        adc_ch_d  = (state_d == ST_CAPTURE) ? ch_d : CH_CLEAR;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ch_q          <= CH_CLEAR;
            retry_q       <= '0;
            frame_cnt_q   <= '0;
            adc_req_q     <= 1'b0;
            adc_ch_q      <= CH_CLEAR;
            tx_start_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            err_nack_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                snap_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            retry_q       <= retry_d;
            frame_cnt_q   <= frame_cnt_d;
            adc_req_q     <= adc_req_d;
            adc_ch_q      <= adc_ch_d;
            tx_start_q    <= tx_start_d;
            err_overrun_q <= err_overrun_d;
            err_nack_q    <= err_nack_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
                snap_q[i]   <= snap_d[i];
            end
        end
    end

    assign adc_req       = adc_req_q;
    assign adc_ch        = adc_ch_q;
    assign tx_start      = tx_start_q;
    assign clear_data    = snap_q[CH_CLEAR];
    assign red_data      = snap_q[CH_RED];
    assign green_data    = snap_q[CH_GREEN];
    assign blue_data     = snap_q[CH_BLUE];
    assign infrared_data = snap_q[CH_IR];
    assign frame_cnt     = frame_cnt_q;
    assign err_overrun   = err_overrun_q;
    assign err_nack      = err_nack_q;

endmodule

// File: tb/tb_color_frame_scheduler.sv
// Scoreboard bench for color_frame_scheduler: random ADC samples, scripted I2C responses.
module tb_color_frame_scheduler;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] period;
    logic        err_clr;
    logic        adc_req;
    logic [2:0]  adc_ch;
    logic        adc_valid;
    logic [15:0] adc_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_nack;
    logic [15:0] clear_data, red_data, green_data, blue_data, infrared_data;
    logic [7:0]  frame_cnt;
    logic        err_overrun;
    logic        err_nack;

    color_frame_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .period        (period),
        .err_clr       (err_clr),
        .adc_req       (adc_req),
        .adc_ch        (adc_ch),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_nack       (tx_nack),
        .clear_data    (clear_data),
        .red_data      (red_data),
        .green_data    (green_data),
        .blue_data     (blue_data),
        .infrared_data (infrared_data),
        .frame_cnt     (frame_cnt),
        .err_overrun   (err_overrun),
        .err_nack      (err_nack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  fc;
        logic [15:0] ir, bl, gr, rd, cl;
    } snap_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic busy_at_edge = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) busy_at_edge <= tx_busy;

    // Reference-model state
    snap_t       sb[$];
    snap_t       cur_exp;
    logic [15:0] shd[5];
    logic [7:0]  exp_frames;
    int          exp_ch, lat, adc_lat, tx_lat, tx_cnt, attempts;
    int          frames_ended = 0, frame_starts = 0, pulses = 0;
    int          last_pulse_cyc = 0, last_start_cyc = 0;
    bit          have_last, check_interval, exp_err_nack;
    logic        prev_req, prev_start;
    int          script[$];
    logic        busy_model = 1'b0;
    logic        busy_force = 1'b0;

    assign tx_busy = busy_model | busy_force;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ended(input int target, input int budget, input string name);
        for (int i = 0; i < budget && frames_ended < target; i++) step();
        chk(name, 64'(frames_ended >= target), 64'd1);
    endtask

    // Environment: output monitor + scoreboard, ADC responder, I2C responder.
    task automatic env_loop();
        logic [15:0] d;
        snap_t s;
        int resp;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            tx_done   = 1'b0;
            tx_nack   = 1'b0;
            if (!rst_n) begin
                sb.delete();
                script.delete();
                cur_exp = '0;
                exp_frames = 8'd0;
                prev_req = 1'b0;
                prev_start = 1'b0;
                have_last = 1'b0;
                lat = 0;
                exp_ch = 0;
                busy_model = 1'b0;
                tx_cnt = 0;
                attempts = 0;
                exp_err_nack = 1'b0;
                continue;
            end
            if (!check_interval) have_last = 1'b0;

            // Monitor: every tx_start must present the most recently committed frame.
            if (tx_start) begin
                pulses++;
                last_pulse_cyc = cyc;
                chk("tx_start_while_busy", 64'(busy_at_edge), 64'd0);
                chk("tx_start_width", 64'(prev_start), 64'd0);
                if (sb.size() > 0) cur_exp = sb.pop_front();
                chk("snap_clear", 64'(clear_data), 64'(cur_exp.cl));
                chk("snap_red", 64'(red_data), 64'(cur_exp.rd));
                chk("snap_green", 64'(green_data), 64'(cur_exp.gr));
                chk("snap_blue", 64'(blue_data), 64'(cur_exp.bl));
                chk("snap_ir", 64'(infrared_data), 64'(cur_exp.ir));
                chk("frame_cnt", 64'(frame_cnt), 64'(cur_exp.fc));
            end
            prev_start = tx_start;

            // ADC: answer each request after adc_lat cycles with a fresh random sample.
            if (adc_req) begin
                if (!prev_req) begin
                    frame_starts++;
                    if (check_interval && have_last)
                        chk("tick_interval", 64'(cyc - last_start_cyc), 64'(period));
                    have_last = check_interval;
                    last_start_cyc = cyc;
                    exp_ch = 0;
                    lat = 0;
                end
                if (lat >= adc_lat) begin
                    chk("adc_ch", 64'(adc_ch), 64'(exp_ch));
                    d = 16'($urandom);
                    adc_valid = 1'b1;
                    adc_data = d;
                    if (exp_ch < 5) shd[exp_ch] = d;
                    if (exp_ch == 4) begin
                        exp_frames = exp_frames + 8'd1;
                        s.fc = exp_frames;
                        s.cl = shd[0];
                        s.rd = shd[1];
                        s.gr = shd[2];
                        s.bl = shd[3];
                        s.ir = shd[4];
                        sb.push_back(s);
                    end
                    exp_ch++;
                    lat = 0;
                end else begin
                    lat++;
                end
            end else if ($urandom_range(3, 0) == 0) begin
                adc_valid = 1'b1;
                adc_data = 16'($urandom);
            end
            prev_req = adc_req;

            // I2C sender: 0 = done, 1 = nack, 2 = done and nack together.
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    resp = (script.size() > 0) ? script.pop_front() : 0;
                    tx_done = (resp != 1);
                    tx_nack = (resp != 0);
                    busy_model = 1'b0;
                    if (tx_nack) begin
                        attempts++;
                        if (attempts > MAX_RETRY) begin
                            exp_err_nack = 1'b1;
                            frames_ended++;
                            attempts = 0;
                        end
                    end else begin
                        frames_ended++;
                        attempts = 0;
                    end
                end
            end
            if (tx_start) begin
                busy_model = 1'b1;
                tx_cnt = tx_lat;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_adc_req"}, 64'(adc_req), 64'd0);
        chk({tag, "_adc_ch"}, 64'(adc_ch), 64'd0);
        chk({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        chk({tag, "_clear"}, 64'(clear_data), 64'd0);
        chk({tag, "_red"}, 64'(red_data), 64'd0);
        chk({tag, "_green"}, 64'(green_data), 64'd0);
        chk({tag, "_blue"}, 64'(blue_data), 64'd0);
        chk({tag, "_ir"}, 64'(infrared_data), 64'd0);
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        chk({tag, "_err_overrun"}, 64'(err_overrun), 64'd0);
        chk({tag, "_err_nack"}, 64'(err_nack), 64'd0);
    endtask

    initial begin
        int p0, f0, s0, drop_cyc;
        logic [7:0] fc0;
        rst_n = 1'b0;
        enable = 1'b0;
        period = 16'd100;
        err_clr = 1'b0;
        adc_lat = 2;
        tx_lat = 30;
        check_interval = 1'b1;
        adc_valid = 1'b0;
        adc_data = '0;
        tx_done = 1'b0;
        tx_nack = 1'b0;
        fork
            env_loop();
        join_none
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Basic frames at a relaxed period
        enable = 1'b1;
        wait_ended(3, 700, "basic_frames_done");
        chk("basic_pulses", 64'(pulses), 64'd3);
        chk("basic_err_overrun", 64'(err_overrun), 64'd0);
        chk("basic_err_nack", 64'(err_nack), 64'd0);

        // NACK retries
        tx_lat = 8;
        adc_lat = 1;
        script = '{1, 1, 0};
        p0 = pulses; f0 = frames_ended;
        wait_ended(f0 + 1, 400, "nack2_done");
        chk("nack2_pulses", 64'(pulses - p0), 64'd3);
        chk("nack2_err_nack", 64'(err_nack), 64'(exp_err_nack));
        script = '{1, 1, 1, 1};
        p0 = pulses; f0 = frames_ended;
        wait_ended(f0 + 1, 400, "nack4_done");
        chk("nack4_pulses", 64'(pulses - p0), 64'(MAX_RETRY + 1));
        step();
        chk("nack4_err_nack", 64'(err_nack), 64'(exp_err_nack));
        script = '{2, 0};
        p0 = pulses; f0 = frames_ended;
        wait_ended(f0 + 1, 400, "both_done");
        chk("both_pulses", 64'(pulses - p0), 64'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_err_nack = 1'b0;
        step();
        chk("nack_cleared", 64'(err_nack), 64'(exp_err_nack));

        // Busy hold at commit
        tx_lat = 10;
        p0 = pulses; f0 = frames_ended;
        for (int i = 0; i < 200 && !adc_req; i++) step();
        busy_force = 1'b1;
        fc0 = frame_cnt;
        for (int i = 0; i < 100 && frame_cnt == fc0; i++) step();
        repeat (10) step();
        chk("busy_no_early", 64'(pulses - p0), 64'd0);
        busy_force = 1'b0;
        drop_cyc = cyc;
        for (int i = 0; i < 20 && pulses == p0; i++) step();
        chk("busy_release_cycle", 64'(last_pulse_cyc - drop_cyc), 64'd1);
        wait_ended(f0 + 1, 200, "busy_done");
        chk("pre_overrun_flag", 64'(err_overrun), 64'd0);

        // Overrun: period far shorter than a frame
        check_interval = 1'b0;
        period = 16'd5;
        adc_lat = 3;
        tx_lat = 4;
        f0 = frames_ended;
        wait_ended(f0 + 3, 600, "overrun_frames_done");
        chk("overrun_flag", 64'(err_overrun), 64'd1);
        enable = 1'b0;
        repeat (100) step();
        chk("overrun_idle_req", 64'(adc_req), 64'd0);
        chk("overrun_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        chk("overrun_cleared", 64'(err_overrun), 64'd0);

        // Disable during capture of channel 2
        period = 16'd50;
        adc_lat = 2;
        tx_lat = 10;
        enable = 1'b1;
        for (int i = 0; i < 200 && !(adc_req && adc_ch == 3'd2); i++) step();
        chk("mid_reached_ch2", 64'(adc_req && adc_ch == 3'd2), 64'd1);
        enable = 1'b0;
        f0 = frames_ended;
        wait_ended(f0 + 1, 200, "mid_frame_done");
        s0 = frame_starts;
        repeat (150) step();
        chk("mid_no_new_frame", 64'(frame_starts - s0), 64'd0);
        chk("mid_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        chk("mid_err_overrun", 64'(err_overrun), 64'd0);

        // Reset while waiting on the sender
        period = 16'd100;
        tx_lat = 30;
        enable = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 300 && pulses == p0; i++) step();
        chk("rst_tx_started", 64'(pulses - p0), 64'd1);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) step();
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (2) step();
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("post_rst_adc_req", 64'(adc_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
